// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter for the single register-file write port.
//
// N write-back requesters (ALU, load unit, CSR path, debug) share the regm
// bank's cen/din. At most one requester is granted per cycle. The winner gets
// a one-cycle ack, and its register index and data are driven as registered
// write strobe/address/data. Register 0 is hardwired zero: a request to it is
// acked, but wr_en stays low.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - asynchronous reset, active low
//   stall    - register bank busy: no new grant this cycle
//   req      - per-requester level write request, held until acked
//   addr_i   - packed register indices, requester k at [k*AW +: AW]
//   data_i   - packed write data, requester k at [k*WIDTH +: WIDTH]
//   ack      - one-hot, one-cycle acknowledge to the granted requester
//   wr_en    - register bank cen
//   wr_addr  - register bank write index
//   wr_data  - register bank din
//   grant_id - index of the last granted requester
//
// Optional feature macro: WBARB_FIXED_PRIO_EN
//   When defined, requester 0 always wins whenever it is eligible. Requesters
//   1..N-1 arbitrate round-robin among themselves, and the pointer only
//   follows their grants.
module wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int AW    = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [N-1:0]       req,
  input  logic [N*AW-1:0]    addr_i,
  input  logic [N*WIDTH-1:0] data_i,
  output logic [N-1:0]       ack,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [WIDTH-1:0]   wr_data,
  output logic [IDW-1:0]     grant_id
);

  logic [N-1:0]     ack_q, ack_d;
  logic             wrEn_q, wrEn_d;
  logic [AW-1:0]    wrAddr_q, wrAddr_d;
  logic [WIDTH-1:0] wrData_q, wrData_d;
  logic [IDW-1:0]   grantId_q, grantId_d;
  logic [IDW-1:0]   last_q, last_d;

  logic [N-1:0]     elig;
  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   scanSel;
  int               scanIdx;
  logic [N-1:0]     grantOneHot;
  logic [AW-1:0]    selAddr;
  logic [WIDTH-1:0] selData;

  // A requester acked this cycle is masked out. It may still hold req for
  // one cycle, and it must not be granted twice for the same request.
  // The scan starts one past the last winner and wraps around.
  always_comb begin
    elig    = req & ~ack_q;
    found   = 1'b0;
    winner  = '0;
    scanIdx = 0;
    scanSel = '0;
`ifdef WBARB_FIXED_PRIO_EN
    if (elig[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
    for (int i = 1; i <= N; i++) begin
      scanIdx = (int'(last_q) + i) % N;
      scanSel = IDW'(scanIdx);
`ifdef WBARB_FIXED_PRIO_EN
      if (!found && scanIdx != 0 && elig[scanSel]) begin
`else
      if (!found && elig[scanSel]) begin
`endif
        found  = 1'b1;
        winner = scanSel;
      end
    end
  end

  // Steer the winner's index and data, and build its one-hot ack.
  always_comb begin
    selAddr     = '0;
    selData     = '0;
    grantOneHot = '0;
    for (int k = 0; k < N; k++) begin
      if (winner == IDW'(k)) begin
        selAddr        = addr_i[k*AW +: AW];
        selData        = data_i[k*WIDTH +: WIDTH];
        grantOneHot[k] = 1'b1;
      end
    end
  end

  // ack and wr_en are pulses, so they default low. Address, data, grant id
  // and pointer hold when nothing is granted.
  always_comb begin
    ack_d     = '0;
    wrEn_d    = 1'b0;
    wrAddr_d  = wrAddr_q;
    wrData_d  = wrData_q;
    grantId_d = grantId_q;
    last_d    = last_q;
    if (!stall && found) begin
      ack_d     = grantOneHot;
      wrEn_d    = (selAddr != '0);
      wrAddr_d  = selAddr;
      wrData_d  = selData;
      grantId_d = winner;
`ifdef WBARB_FIXED_PRIO_EN
      if (winner != '0) begin
        last_d = winner;
      end
`else
      last_d = winner;
`endif
    end
  end

  // The pointer resets to N-1, so requester 0 is first in line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q     <= '0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      grantId_q <= IDW'(N - 1);
      last_q    <= IDW'(N - 1);
    end else begin
      ack_q     <= ack_d;
      wrEn_q    <= wrEn_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
      grantId_q <= grantId_d;
      last_q    <= last_d;
    end
  end

  assign ack      = ack_q;
  assign wr_en    = wrEn_q;
  assign wr_addr  = wrAddr_q;
  assign wr_data  = wrData_q;
  assign grant_id = grantId_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter.
//
// Directed scenarios compare against hand-derived constants. A randomized
// run compares every cycle against a behavioural model of the arbitration
// rules.
module tb_wb_arbiter;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int AW    = 4;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               stall;
  logic [N-1:0]       req;
  logic [N*AW-1:0]    addr_i;
  logic [N*WIDTH-1:0] data_i;
  logic [N-1:0]       ack;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [IDW-1:0]     grant_id;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state; mAck = -1 means no ack this cycle.
  int               mAck;
  int               mLast;
  int               mGrant;
  logic             mWrEn;
  logic [AW-1:0]    mWrAddr;
  logic [WIDTH-1:0] mWrData;

  always #5 clk = ~clk;

  wb_arbiter #(.WIDTH(WIDTH), .N(N), .AW(AW), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req),
    .addr_i(addr_i), .data_i(data_i), .ack(ack), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .grant_id(grant_id)
  );

  task automatic modelReset();
    mAck    = -1;
    mLast   = N - 1;
    mGrant  = N - 1;
    mWrEn   = 1'b0;
    mWrAddr = '0;
    mWrData = '0;
  endtask

  // One rising edge of the arbitration rules, applied to the inputs present
  // at that edge.
  task automatic modelStep();
    int g;
    int k;
    g = -1;
    if (!stall) begin
`ifdef WBARB_FIXED_PRIO_EN
      if (req[0] && mAck != 0) g = 0;
`endif
      for (int i = 1; i <= N; i++) begin
        k = (mLast + i) % N;
`ifdef WBARB_FIXED_PRIO_EN
        if (g < 0 && k != 0 && req[k] && mAck != k) g = k;
`else
        if (g < 0 && req[k] && mAck != k) g = k;
`endif
      end
    end
    if (g >= 0) begin
      mAck    = g;
      mGrant  = g;
`ifdef WBARB_FIXED_PRIO_EN
      if (g != 0) mLast = g;
`else
      mLast   = g;
`endif
      mWrAddr = addr_i[g*AW +: AW];
      mWrData = data_i[g*WIDTH +: WIDTH];
      mWrEn   = (mWrAddr != '0);
    end else begin
      mAck  = -1;
      mWrEn = 1'b0;
    end
  endtask

  function automatic logic [N-1:0] modelAckVec();
    logic [N-1:0] v;
    v = '0;
    if (mAck >= 0) v[mAck] = 1'b1;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic applyReset();
    req   = '0;
    stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    stall  = 1'b0;
    req    = '0;
    addr_i = '0;
    data_i = '0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    compared++;
    if ({ack, wr_en, wr_addr, wr_data, grant_id} !== {4'b0000, 1'b0, 4'h0, 32'h0, 2'd3}) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got ack=%b en=%b addr=%h data=%h gid=%0d, want 0000/0/0/0/3",
               ack, wr_en, wr_addr, wr_data, grant_id);
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    applyReset();
    req             = 4'b0001;
    addr_i[0 +: AW] = 4'd3;
    data_i[0 +: 32] = 32'hDEAD_BEEF;
    cycle();
    compared++;
    if ({ack, wr_en, wr_addr, wr_data, grant_id} !== {4'b0001, 1'b1, 4'd3, 32'hDEAD_BEEF, 2'd0}) begin
      mismatched++;
      $display("[TB] FAIL single_grant: got ack=%b en=%b addr=%h data=%h gid=%0d, want 0001/1/3/deadbeef/0",
               ack, wr_en, wr_addr, wr_data, grant_id);
    end
    cycle();
    compared++;
    if ({ack, wr_en} !== {4'b0000, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL single_no_double: got ack=%b en=%b, want 0000/0", ack, wr_en);
    end
    req = '0;
    cycle();
  endtask

  task automatic test_round_robin();
    int order[5];
`ifdef WBARB_FIXED_PRIO_EN
    order = '{0, 1, 0, 2, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    applyReset();
    for (int k = 0; k < N; k++) begin
      addr_i[k*AW +: AW]       = AW'(k + 1);
      data_i[k*WIDTH +: WIDTH] = 32'hA000_0000 + k;
    end
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      compared++;
      if (ack !== (4'b0001 << order[i]) || grant_id !== IDW'(order[i]) || wr_en !== 1'b1 ||
          wr_addr !== AW'(order[i] + 1) || wr_data !== (32'hA000_0000 + order[i])) begin
        mismatched++;
        $display("[TB] FAIL round_robin[%0d]: got ack=%b gid=%0d en=%b addr=%h data=%h, want grant %0d",
                 i, ack, grant_id, wr_en, wr_addr, wr_data, order[i]);
      end
    end
    req = '0;
    cycle();
  endtask

  task automatic test_addr_zero();
    applyReset();
    req               = 4'b0100;
    addr_i[2*AW +: AW] = 4'd0;
    data_i[2*32 +: 32] = 32'h1234_5678;
    cycle();
    compared++;
    if ({ack, wr_en, wr_addr, wr_data, grant_id} !== {4'b0100, 1'b0, 4'd0, 32'h1234_5678, 2'd2}) begin
      mismatched++;
      $display("[TB] FAIL addr_zero: got ack=%b en=%b addr=%h data=%h gid=%0d, want 0100/0/0/12345678/2",
               ack, wr_en, wr_addr, wr_data, grant_id);
    end
    req = '0;
    cycle();
  endtask

  // Runs right after test_addr_zero: the pointer is at 2, and the outputs
  // still hold that write's address/data.
  task automatic test_stall();
    addr_i[1*AW +: AW] = 4'd9;
    data_i[1*32 +: 32] = 32'hCAFE_0001;
    addr_i[2*AW +: AW] = 4'd10;
    stall = 1'b1;
    req   = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      cycle();
      compared++;
      if ({ack, wr_en, wr_addr, wr_data, grant_id} !== {4'b0000, 1'b0, 4'd0, 32'h1234_5678, 2'd2}) begin
        mismatched++;
        $display("[TB] FAIL stall_hold[%0d]: got ack=%b en=%b addr=%h data=%h gid=%0d, want 0000/0/0/12345678/2",
                 i, ack, wr_en, wr_addr, wr_data, grant_id);
      end
    end
    stall = 1'b0;
    cycle();
    compared++;
    if ({ack, wr_en, wr_addr, wr_data, grant_id} !== {4'b0010, 1'b1, 4'd9, 32'hCAFE_0001, 2'd1}) begin
      mismatched++;
      $display("[TB] FAIL stall_release: got ack=%b en=%b addr=%h data=%h gid=%0d, want 0010/1/9/cafe0001/1",
               ack, wr_en, wr_addr, wr_data, grant_id);
    end
    req = '0;
    cycle();
  endtask

  task automatic test_async_reset();
    applyReset();
    req             = 4'b0001;
    addr_i[0 +: AW] = 4'd5;
    data_i[0 +: 32] = 32'h5555_AAAA;
    cycle();
    compared++;
    if (wr_en !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL async_pre: got wr_en=%b, want 1", wr_en);
    end
    #2;
    reset = 1'b0;
    #1;
    compared++;
    if ({ack, wr_en, wr_addr, wr_data, grant_id} !== {4'b0000, 1'b0, 4'd0, 32'h0, 2'd3}) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got ack=%b en=%b addr=%h data=%h gid=%0d, want 0000/0/0/0/3",
               ack, wr_en, wr_addr, wr_data, grant_id);
    end
    modelReset();
    req = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_pairs();
    int exp01[4];
    int exp02[4];
    exp01 = '{0, 1, 0, 1};
    exp02 = '{0, 2, 0, 2};
    applyReset();
    for (int k = 0; k < N; k++) addr_i[k*AW +: AW] = AW'(k + 4);
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      cycle();
      compared++;
      if (ack !== (4'b0001 << exp01[i]) || grant_id !== IDW'(exp01[i])) begin
        mismatched++;
        $display("[TB] FAIL pair_0011[%0d]: got ack=%b gid=%0d, want grant %0d", i, ack, grant_id, exp01[i]);
      end
    end
    applyReset();
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      cycle();
      compared++;
      if (ack !== (4'b0001 << exp02[i]) || grant_id !== IDW'(exp02[i])) begin
        mismatched++;
        $display("[TB] FAIL pair_0101[%0d]: got ack=%b gid=%0d, want grant %0d", i, ack, grant_id, exp02[i]);
      end
    end
    req = '0;
    cycle();
  endtask

  task automatic test_random();
    applyReset();
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      req   = 4'($urandom);
      for (int k = 0; k < N; k++) begin
        addr_i[k*AW +: AW]       = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
        data_i[k*WIDTH +: WIDTH] = $urandom;
      end
      cycle();
      compared++;
      if (ack !== modelAckVec() || wr_en !== mWrEn || wr_addr !== mWrAddr ||
          wr_data !== mWrData || grant_id !== IDW'(mGrant)) begin
        mismatched++;
        $display("[TB] FAIL random[%0d]: got ack=%b en=%b addr=%h data=%h gid=%0d, want ack=%b en=%b addr=%h data=%h gid=%0d",
                 c, ack, wr_en, wr_addr, wr_data, grant_id,
                 modelAckVec(), mWrEn, mWrAddr, mWrData, mGrant);
      end
    end
    req   = '0;
    stall = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_addr_zero();
    test_stall();
    test_async_reset();
    test_pairs();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Round-robin arbiter sharing the single register-file write port (the regm bank's cen/din) among N write-back requesters (ALU, load unit, CSR path, debug). Each cycle it picks at most one requester, drives registered write strobe/address/data to the register bank and returns a one-cycle ack to the winner. Sits between the execute/memory stages and the register bank in cpu1.

Parameters:
WIDTH, 32, data width of each write request and of wr_data
N, 4, number of requesters (2..8)
AW, 4, register index width (2^AW registers)
IDW, 2, grant id width, must equal clog2(N)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
stall  input  1  register bank busy: no new grant this cycle
req  input  N  per-requester write request, level, held until acked
addr_i  input  N*AW  packed register indices, requester k at [k*AW +: AW]
data_i  input  N*WIDTH  packed write data, requester k at [k*WIDTH +: WIDTH]
ack  output  N  one-hot one-cycle acknowledge to granted requester
wr_en  output  1  register bank cen
wr_addr  output  AW  register bank write index
wr_data  output  WIDTH  register bank din
grant_id  output  IDW  index of last granted requester

Behaviour:
- Reset (reset=0, async): ack=0, wr_en=0, wr_addr=0, wr_data=0, grant_id=N-1 (so requester 0 wins first), last pointer=N-1.
- Eligible set each cycle: elig[k] = req[k] & ~ack[k]; requester acked in current cycle is masked, so a requester still holding req one cycle after ack is not granted twice.
- Selection: first eligible index scanning (last+1) mod N upward with wrap-around; combinational from elig and last.
- Rising edge, stall=0, elig!=0, winner g: ack<=one-hot(g), grant_id<=g, last<=g, wr_addr<=addr_i[g], wr_data<=data_i[g], wr_en<=(addr_i[g]!=0).
- Register 0 is hardwired zero: request to addr 0 is acked normally but wr_en stays 0; wr_addr/wr_data still updated.
- Rising edge, stall=1 or elig==0: ack<=0, wr_en<=0, last/grant_id/wr_addr/wr_data hold.
- Latency: req sampled at edge n -> ack, wr_en, wr_addr, wr_data valid during cycle n+1; bank writes at edge n+1.
- Throughput: one write per cycle when different requesters alternate; a single continuously requesting source gets every other cycle.
- Requester must drop req or present a new request in the cycle ack is high; arbiter does not check.
- req deasserted before ack: withdrawn, no write, no error.
- Simultaneous stall rise and ack: ack already issued completes; stall only blocks the next grant.
- Reset mid-write: outputs clear immediately; in-flight write lost.
- Invariants: popcount(ack)<=1; wr_en=1 implies ack!=0; grant_id==index of ack whenever ack!=0.

Optional Feature:
WBARB_FIXED_PRIO_EN: when defined, requester 0 always wins if eligible (debug/CSR path priority); remaining requesters arbitrate round-robin among themselves, with last updated only by grants to 1..N-1. Undefined: pure round-robin over all N as above.

Test Plan:
- Reset release, req=4'b0001, addr_i[0]=3, data_i[0]=32'hDEAD_BEEF -> next cycle ack=0001, wr_en=1, wr_addr=3, wr_data=DEADBEEF, grant_id=0; req held one more cycle -> no second ack.
- req=4'b1111 held, all addr nonzero, pointer at reset -> grant order 0,1,2,3,0,... with acked source masked; 4 grants within 5 cycles after first.
- req[2] with addr_i[2]=0 -> ack=0100, wr_en=0, grant_id=2.
- stall=1 for 3 cycles with req=0110 -> ack=0, wr_en=0, outputs hold; stall=0 -> ack=0010 next cycle.
- Assert reset=0 asynchronously while wr_en=1 -> wr_en, ack, wr_addr, wr_data 0 before next clock edge; grant_id=3.
- WBARB_FIXED_PRIO_EN defined, req=0011 continuous -> 0 granted whenever not masked: grants 0,1,0,1; undefined -> same pattern via round-robin, req=0101 alternates 0,2.
